// File: rtl/cordic_pkg.sv
// Shared fixed-point constants and types for the CORDIC trig pipeline.
// Word format: 1 sign bit, 1 integer bit, 14 fractional bits.
package cordic_pkg;

   localparam int SYM_WIDTH = 1;
   localparam int INT_WIDTH = 1;
   localparam int DEC_WIDTH = 14;
   localparam int W         = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;

   localparam logic [W-1:0] PI_HALF = 16'd25736;
   localparam logic [W-1:0] K_INV   = 16'd9949;

   typedef logic [1:0] quad_t;

   localparam quad_t QUAD_0 = 2'd0;
   localparam quad_t QUAD_1 = 2'd1;
   localparam quad_t QUAD_2 = 2'd2;
   localparam quad_t QUAD_3 = 2'd3;

endpackage

// File: rtl/cordic_sideband_dly.sv
// {valid, quad} shift line that keeps quadrant tags aligned with the rotation chain.
module cordic_sideband_dly
   import cordic_pkg::*;
#(
   parameter int DEPTH = 14
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  i_valid,
   input  quad_t i_quad,
   output logic  o_valid,
   output quad_t o_quad,
   output logic  o_any_valid
);

   logic [DEPTH-1:0]        r_valid;
   logic [DEPTH-1:0][1:0]   r_quad;

   // shift one entry per enabled cycle; reset clears every valid at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_quad  <= '0;
      end else if (en) begin
         r_valid <= {r_valid[DEPTH-2:0], i_valid};
         r_quad  <= {r_quad[DEPTH-2:0], i_quad};
      end
   end

   assign o_valid     = r_valid[DEPTH-1];
   assign o_quad      = r_quad[DEPTH-1];
   assign o_any_valid = |r_valid;

endmodule

// File: rtl/cordic_trig_pre.sv
// Pre-stage of cordic_trig: splits the quadrant off a turn-normalised phase,
// scales the in-quadrant fraction to radians and seeds iteration stage 0.
module cordic_trig_pre
   import cordic_pkg::*;
#(
   parameter int PHASE_WIDTH = 16,
   parameter int ITER_NUM    = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [PHASE_WIDTH-1:0] phase_in,
   output logic signed [W-1:0]    x_0,
   output logic signed [W-1:0]    y_0,
   output logic signed [W-1:0]    z_0,
   output logic                   out_valid,
   output logic [1:0]             out_quad,
   output logic                   busy
);

   localparam int FRAC_W = PHASE_WIDTH - 2;
   localparam int PROD_W = FRAC_W + W;
   localparam logic [PROD_W-1:0] RND = PROD_W'(1'b1) << (FRAC_W - 1);

   logic              r_v1;
   quad_t             r_q1;
   logic [FRAC_W-1:0] r_f1;

   logic              r_v2;
   quad_t             r_q2;
   logic [W-1:0]      r_x0;
   logic [W-1:0]      r_y0;
   logic [W-1:0]      r_z0;

   logic [PROD_W-1:0] w_prod;
   logic              w_sb_any;

   // stage 1: quadrant / fraction split
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_q1 <= QUAD_0;
         r_f1 <= '0;
      end else if (en) begin
         r_v1 <= in_valid;
         r_q1 <= phase_in[PHASE_WIDTH-1 -: 2];
         r_f1 <= phase_in[FRAC_W-1:0];
      end
   end

   // fraction * pi/2 never exceeds PROD_W bits, so the rounded angle fits W-1 bits
   assign w_prod = PROD_W'(r_f1) * PROD_W'(PI_HALF);

   // stage 2: seed registers; data is loaded every enabled cycle, valid masks it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v2 <= 1'b0;
         r_q2 <= QUAD_0;
         r_x0 <= '0;
         r_y0 <= '0;
         r_z0 <= '0;
      end else if (en) begin
         r_v2 <= r_v1;
         r_q2 <= r_q1;
         r_x0 <= r_v1 ? K_INV : '0;
         r_y0 <= '0;
         r_z0 <= W'((w_prod + RND) >> FRAC_W);
      end
   end

   assign x_0 = r_x0;
   assign y_0 = r_y0;
   assign z_0 = r_z0;

   cordic_sideband_dly #(
      .DEPTH (ITER_NUM)
   ) u_sideband (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .i_valid     (r_v2),
      .i_quad      (r_q2),
      .o_valid     (out_valid),
      .o_quad      (out_quad),
      .o_any_valid (w_sb_any)
   );

   assign busy = r_v1 | r_v2 | w_sb_any;

endmodule

// File: tb/tb_cordic_trig_pre.sv
// Directed self-checking bench for cordic_trig_pre.
module tb_cordic_trig_pre;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        in_valid;
   logic [15:0] phase_in;
   logic signed [15:0] x_0;
   logic signed [15:0] y_0;
   logic signed [15:0] z_0;
   logic        out_valid;
   logic [1:0]  out_quad;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int ecount;
   int seen;

   logic        tab_en [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [15:0] tab_ph [6] = '{16'h0000, 16'h4000, 16'h4000, 16'h8000, 16'hC000, 16'hC000};

   cordic_trig_pre dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .phase_in  (phase_in),
      .x_0       (x_0),
      .y_0       (y_0),
      .z_0       (z_0),
      .out_valid (out_valid),
      .out_quad  (out_quad),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one input, then check seeds after 2 edges and out_valid exactly at edge 16
   task automatic run_single(input logic [15:0] ph, input int exp_z, input int exp_q);
      en = 1'b1; in_valid = 1'b1; phase_in = ph;
      tick();
      in_valid = 1'b0; phase_in = 16'h0000;
      tick();
      chk("seed_x", {16'd0, x_0}, 32'd9949);
      chk("seed_y", {16'd0, y_0}, 32'd0);
      chk("seed_z", {16'd0, z_0}, exp_z);
      chk("busy_inflight", {31'd0, busy}, 32'd1);
      for (int k = 3; k <= 15; k++) begin
         tick();
         chk("out_valid_early", {31'd0, out_valid}, 32'd0);
      end
      tick();
      chk("out_valid_16", {31'd0, out_valid}, 32'd1);
      chk("out_quad_16", {30'd0, out_quad}, exp_q);
      tick();
      chk("out_valid_17", {31'd0, out_valid}, 32'd0);
      chk("busy_drained", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; phase_in = 16'h0000;
      #2;
      chk("rst_x", {16'd0, x_0}, 32'd0);
      chk("rst_y", {16'd0, y_0}, 32'd0);
      chk("rst_z", {16'd0, z_0}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_quad", {30'd0, out_quad}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // idle with en=1: nothing may appear
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
         chk("idle_busy", {31'd0, busy}, 32'd0);
      end
      chk("idle_x", {16'd0, x_0}, 32'd0);
      chk("idle_z", {16'd0, z_0}, 32'd0);

      // z = (f*25736 + 8192) >> 14
      run_single(16'h0000, 0, 0);
      run_single(16'h6000, 12868, 1);      // f=8192 -> 12868.5 floor
      run_single(16'hFFFF, 25734, 3);      // f=16383 -> 421641080/16384 = 25734.4
      run_single(16'h0001, 2, 0);          // 25736+8192=33928 -> 2

      // back-to-back with en stalls; outputs at enabled edges 16..19, quads 0..3
      ecount = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (i < 6) begin
            en = tab_en[i]; in_valid = 1'b1; phase_in = tab_ph[i];
         end else begin
            en = ((i % 3) != 2); in_valid = 1'b0; phase_in = 16'h0000;
         end
         tick();
         if (en) begin
            ecount++;
            if (out_valid) seen++;
            if (ecount >= 16 && ecount <= 19) begin
               chk("b2b_valid", {31'd0, out_valid}, 32'd1);
               chk("b2b_quad", {30'd0, out_quad}, ecount - 16);
            end else begin
               chk("b2b_idle", {31'd0, out_valid}, 32'd0);
            end
         end
      end
      chk("b2b_count", seen, 32'd4);
      chk("b2b_busy_end", {31'd0, busy}, 32'd0);

      // reset while 5 entries are in flight
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         phase_in = 16'h1000 + 16'(i) * 16'h4000;
         tick();
      end
      in_valid = 1'b0; phase_in = 16'h0000;
      for (int i = 0; i < 11; i++) tick();
      chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
      chk("mid_out_quad", {30'd0, out_quad}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_quad", {30'd0, out_quad}, 32'd0);
      chk("async_x", {16'd0, x_0}, 32'd0);
      tick();
      rst = 1'b0;
      run_single(16'h2000, 12868, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
